// File: rtl/sram_controller.sv
// MEM-stage responder: one 32-bit read or write per request, carried out as two
// 16-bit half-accesses on an external asynchronous SRAM.
module sram_controller #(
    parameter int unsigned ACCESS_CYCLES = 2,
    parameter int unsigned BASE_ADDR     = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdEn,
    input  logic        wrEn,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        ready,
    output logic [17:0] sramAddr,
    output logic [15:0] sramDqOut,
    input  logic [15:0] sramDqIn,
    output logic        sramDqOe,
    output logic        sramWeN
);

    typedef enum logic [1:0] {StIdle, StLow, StHigh, StDone} state_e;

    localparam logic [3:0] LastCnt = 4'(ACCESS_CYCLES - 1);

    state_e      state;
    logic [3:0]  cnt;
    logic        is_write;
    logic [16:0] word;
    logic [31:0] wdata;

    logic [31:0] offset;
    logic [3:0]  cnt_inc;
    logic        last;

    assign offset  = address - BASE_ADDR;
    assign cnt_inc = cnt + 4'd1;
    assign last    = (cnt == LastCnt);
    assign ready   = (state == StDone) | ~(rdEn | wrEn);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            cnt       <= 4'd0;
            is_write  <= 1'b0;
            word      <= 17'd0;
            wdata     <= 32'd0;
            readData  <= 32'd0;
            sramAddr  <= 18'd0;
            sramDqOut <= 16'd0;
            sramDqOe  <= 1'b0;
            sramWeN   <= 1'b1;
        end else begin
            unique case (state)
                StIdle: begin
                    if (rdEn | wrEn) begin
                        is_write  <= wrEn;
                        word      <= offset[18:2];
                        wdata     <= writeData;
                        cnt       <= 4'd0;
                        state     <= StLow;
                        sramAddr  <= {offset[18:2], 1'b0};
                        sramDqOut <= writeData[15:0];
                        sramDqOe  <= wrEn;
                        sramWeN   <= ~wrEn;
                    end
                end
                StLow: begin
                    if (last) begin
                        if (!is_write) begin
                            readData[15:0] <= sramDqIn;
                        end
                        cnt       <= 4'd0;
                        state     <= StHigh;
                        sramAddr  <= {word, 1'b1};
                        sramDqOut <= wdata[31:16];
                        sramDqOe  <= is_write;
                        sramWeN   <= ~is_write;
                    end else begin
                        cnt <= cnt_inc;
                        // Release WE one cycle early so address/data outlast the pulse.
                        sramWeN <= ~is_write | (cnt_inc == LastCnt);
                    end
                end
                StHigh: begin
                    if (last) begin
                        if (!is_write) begin
                            readData[31:16] <= sramDqIn;
                        end
                        cnt      <= 4'd0;
                        state    <= StDone;
                        sramDqOe <= 1'b0;
                        sramWeN  <= 1'b1;
                    end else begin
                        cnt     <= cnt_inc;
                        sramWeN <= ~is_write | (cnt_inc == LastCnt);
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench: stimulus pushes expected responses, a negedge monitor pops and
// compares them when the controller completes a request.
module tb_sram_controller;

    localparam int A = 2;

    logic        clk;
    logic        rst;
    logic        rdEn;
    logic        wrEn;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic        ready;
    logic [17:0] sramAddr;
    logic [15:0] sramDqOut;
    logic [15:0] sramDqIn;
    logic        sramDqOe;
    logic        sramWeN;

    sram_controller #(
        .ACCESS_CYCLES(A),
        .BASE_ADDR    (1024)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rdEn     (rdEn),
        .wrEn     (wrEn),
        .address  (address),
        .writeData(writeData),
        .readData (readData),
        .ready    (ready),
        .sramAddr (sramAddr),
        .sramDqOut(sramDqOut),
        .sramDqIn (sramDqIn),
        .sramDqOe (sramDqOe),
        .sramWeN  (sramWeN)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Zero-latency asynchronous SRAM.
    logic [15:0] sram [0:262143];
    assign sramDqIn = sram[sramAddr];
    always @(posedge clk) begin
        if (!sramWeN) sram[sramAddr] <= sramDqOut;
    end

    typedef struct packed {
        logic        is_wr;
        logic [16:0] w;
        logic [31:0] data;
        logic [31:0] rd_exp;
    } exp_t;

    exp_t        q[$];
    logic [31:0] ref_mem [logic [16:0]];
    logic [31:0] last_read;
    int          n_vec;
    int          n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [16:0] word_of(input logic [31:0] addr);
        logic [31:0] off;
        off = (addr - 32'd1024) / 32'd4;
        return off[16:0];
    endfunction

    function automatic logic [31:0] ref_read(input logic [16:0] w);
        return ref_mem.exists(w) ? ref_mem[w] : 32'd0;
    endfunction

    // Monitor: counts stall, write-pulse and drive cycles for the request in flight.
    int stall, we_low, oe_cyc;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            stall = 0; we_low = 0; oe_cyc = 0;
        end else if (rdEn | wrEn) begin
            if (!sramWeN) we_low++;
            if (sramDqOe) oe_cyc++;
            if (!ready) begin
                stall++;
            end else begin
                if (q.size() == 0) begin
                    check("unexpected_ready", 32'(q.size()), 32'd1);
                end else begin
                    e = q.pop_front();
                    check("readData", readData, e.rd_exp);
                    check("stall_cycles", 32'(stall), 32'(2 * A + 1));
                    check("we_low_cycles", 32'(we_low), e.is_wr ? 32'(2 * (A - 1)) : 32'd0);
                    check("oe_cycles", 32'(oe_cyc), e.is_wr ? 32'(2 * A) : 32'd0);
                    if (e.is_wr)
                        check("sram_word", {sram[{e.w, 1'b1}], sram[{e.w, 1'b0}]}, e.data);
                end
                stall = 0; we_low = 0; oe_cyc = 0;
            end
        end
    end

    task automatic issue(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] data);
        exp_t e;
        rdEn = rd; wrEn = wr; address = addr; writeData = data;
        e.is_wr = wr;
        e.w     = word_of(addr);
        e.data  = data;
        if (wr) begin
            ref_mem[e.w] = data;
            e.rd_exp = last_read;
        end else begin
            e.rd_exp  = ref_read(e.w);
            last_read = e.rd_exp;
        end
        q.push_back(e);
    endtask

    // Called in cycle 0 of a request; returns at +1 after the DONE edge.
    task automatic finish_req();
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        address = $urandom; writeData = $urandom;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready) begin got = 1'b1; break; end
        end
        check("ready_timeout", 32'(got), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic req(input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [31:0] data);
        issue(rd, wr, addr, data);
        finish_req();
    endtask

    task automatic idle(input int n);
        rdEn = 1'b0; wrEn = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_ready", 32'(ready), 32'd1);
            check("idle_wen", 32'(sramWeN), 32'd1);
            check("idle_oe", 32'(sramDqOe), 32'd0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        n_vec = 0; n_fail = 0; last_read = 32'd0;
        for (int i = 0; i < 262144; i++) sram[i] = 16'd0;
        sram[6] = 16'h5678; sram[7] = 16'h1234;
        ref_mem[17'd3] = 32'h1234_5678;
        rst = 1'b1; rdEn = 1'b0; wrEn = 1'b0; address = 32'd0; writeData = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_readData", readData, 32'd0);
        check("rst_sramAddr", 32'(sramAddr), 32'd0);
        check("rst_sramDqOut", 32'(sramDqOut), 32'd0);
        check("rst_wen", 32'(sramWeN), 32'd1);
        check("rst_oe", 32'(sramDqOe), 32'd0);
        check("rst_ready", 32'(ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        idle(10);
        req(1'b0, 1'b1, 32'd1032, 32'hDEAD_BEEF);
        idle(1);
        check("sram4", 32'(sram[4]), 32'h0000_BEEF);
        check("sram5", 32'(sram[5]), 32'h0000_DEAD);
        req(1'b1, 1'b0, 32'd1032, 32'h0);
        idle(1);
        req(1'b1, 1'b0, 32'd1032, 32'h0);
        req(1'b1, 1'b0, 32'd1036, 32'h0);
        idle(1);
        req(1'b1, 1'b1, 32'd1024, 32'h0000_A5A5);
        idle(1);
        check("sram0", 32'(sram[0]), 32'h0000_A5A5);

        // Reset during the HIGH half of a write, request held throughout.
        rdEn = 1'b0; wrEn = 1'b1; address = 32'd1040; writeData = 32'hCAFE_F00D;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_wen", 32'(sramWeN), 32'd1);
        check("midrst_oe", 32'(sramDqOe), 32'd0);
        check("midrst_addr", 32'(sramAddr), 32'd0);
        check("midrst_readData", readData, 32'd0);
        check("midrst_ready", 32'(ready), 32'd0);
        last_read = 32'd0;
        @(posedge clk); #1;
        rst = 1'b0;
        issue(1'b0, 1'b1, 32'd1040, 32'hCAFE_F00D);
        finish_req();
        req(1'b1, 1'b0, 32'd1040, 32'h0);

        for (int t = 0; t < 80; t++) begin
            int unsigned op;
            logic [31:0] addr;
            op = $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) addr = $urandom;
            else addr = 32'd1024 + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
            req(op < 2, op >= 2, addr, $urandom);
            if ($urandom_range(0, 2) == 0) begin
                rdEn = 1'b0; wrEn = 1'b0;
                repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
            end
        end
        rdEn = 1'b0; wrEn = 1'b0;
        repeat (3) @(posedge clk);
        check("queue_empty", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
# sram_controller

Memory-side responder for the ARM pipeline's MEM stage. It accepts one 32-bit word read or write per request from the MEM stage (`rdEn`/`wrEn`, byte address, write data). It carries the request out as two 16-bit accesses on the external asynchronous SRAM. It returns `readData` together with the `ready` handshake that the pipeline stage registers use to freeze and advance.

## Interface

Parameters:
- `ACCESS_CYCLES`, default 2: cycles each 16-bit half-access occupies on the SRAM bus. Legal range is 2..15.
- `BASE_ADDR`, default 1024: CPU byte address that maps to SRAM word 0.

Ports:
- `clk`  in  1  single clock. All state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rdEn`  in  1  read request from MEM stage. Held high until `ready`.
- `wrEn`  in  1  write request from MEM stage. Held high until `ready`.
- `address`  in  32  CPU byte address.
- `writeData`  in  32  write data.
- `readData`  out  32  assembled read word, registered.
- `ready`  out  1  combinational. Low freezes the pipeline.
- `sramAddr`  out  18  SRAM half-word address, registered.
- `sramDqOut`  out  16  data driven to SRAM, registered.
- `sramDqIn`  in  16  data returned from SRAM.
- `sramDqOe`  out  1  DQ output enable (1 = controller drives), registered.
- `sramWeN`  out  1  SRAM write enable, active low, registered.

## Operation

- The FSM has four states: IDLE, LOW, HIGH, DONE. A counter `cnt` of 4 bits runs 0..ACCESS_CYCLES-1 in LOW and HIGH.
- In IDLE, when `wrEn | rdEn` is high:
  - Latch the operation. If both are high, `wrEn` wins and the operation is a write.
  - Compute `w = (address - BASE_ADDR) >> 2` and keep bits [16:0]. Wrap-around is modulo 2^17. Address bits [1:0] are ignored.
  - Latch `writeData`.
  - Go to LOW with `cnt = 0`.
- In LOW:
  - Drive `sramAddr = {w, 1'b0}`.
  - For a write, drive `sramDqOut = writeData[15:0]` and `sramDqOe = 1`.
  - `sramWeN = 0` for cnt 0..ACCESS_CYCLES-2 and `1` on the last cycle, so address and data are held one cycle past the write pulse.
  - For a read, `sramDqOe = 0` and `sramWeN = 1`. Sample `sramDqIn` into `readData[15:0]` on the last cycle.
  - After the last cycle, go to HIGH with `cnt = 0`.
- HIGH is identical to LOW except:
  - `sramAddr = {w, 1'b1}`.
  - Write data is `writeData[31:16]`.
  - A read samples into `readData[31:16]`.
  - After the last cycle, go to DONE.
- In DONE, release the bus: `sramDqOe = 0`, `sramWeN = 1`. Go to IDLE unconditionally.
- `ready = (state == DONE) | ~(rdEn | wrEn)`. It never depends on `sramDqIn`.
- `readData` holds its value until the next read overwrites it. Writes never change `readData`.
- Reset values, applied on any `clk` edge with `rst = 1`, including mid-access:
  - state = IDLE, `cnt = 0`.
  - `sramAddr = 0`, `sramDqOut = 0`, `sramDqOe = 0`, `sramWeN = 1`, `readData = 0`.
  - Any in-flight request is abandoned. A half-written word is acceptable.

## Timing

- A request is first seen in cycle 0, while in IDLE. LOW occupies cycles 1..A and HIGH occupies cycles A+1..2A, where A = ACCESS_CYCLES.
- DONE is cycle 2A+1, and it is the only cycle with `ready = 1` while a request is present. The pipeline register loads on that edge. `readData` is already valid during DONE.
- Stall length is 2A+1 cycles. With A = 2, `ready` is low for cycles 0..4 and high in cycle 5.
- Back-to-back requests: DONE → IDLE → a new request is accepted in that IDLE cycle. A request still asserted in DONE is not re-issued, because DONE always returns to IDLE first.
- Request inputs are sampled only in IDLE. Changes to `address`, `writeData`, `rdEn` or `wrEn` during LOW, HIGH or DONE are ignored.
- With no request present, `ready = 1` in every state.

## Test plan

All scenarios use A = 2, BASE_ADDR = 1024, and a behavioural SRAM model with zero read latency.

- **Idle:** hold `rdEn = wrEn = 0` for 10 cycles → `ready = 1` throughout, `sramWeN = 1`, `sramDqOe = 0`.
- **Write:** `wrEn = 1`, `address = 1032`, `writeData = 0xDEADBEEF`.
  - SRAM[4] = 0xBEEF and SRAM[5] = 0xDEAD.
  - `sramWeN` is low for exactly 1 cycle per half.
  - `ready` is high in cycle 5 only.
- **Read back:** `rdEn = 1`, `address = 1032` → `readData = 0xDEADBEEF` in cycle 5, `ready = 1` in cycle 5, `sramDqOe = 0` throughout.
- **Back-to-back reads:** `rdEn` held high across two requests to 1032 and then 1036 (SRAM[6:7] preloaded with 0x5678 and 0x1234).
  - The second request starts in cycle 6.
  - `readData = 0x12345678` in cycle 11.
- **Simultaneous request:** `rdEn = wrEn = 1`, `address = 1024`, `writeData = 0x0000A5A5` → a write is performed, SRAM[0] = 0xA5A5, and `readData` is unchanged.
- **Reset mid-op:** assert `rst` in cycle 3 of a write.
  - The next edge gives state IDLE, `sramWeN = 1`, `sramDqOe = 0`, `sramAddr = 0`, `readData = 0`.
  - After release with the request held, a fresh 6-cycle transaction completes correctly.
